// File: rtl/counter_cmd_arbiter.sv
// Round-robin arbiter that runs load/up/down/read commands on a shared up/down counter.
// Optional build macro CTR_ARB_SAT_EN adds sat_o and stops counting at 0 / all-ones.
module counter_cmd_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  // Request handshake: req_i[i] is a level that the requester holds, with its op/arg
  // stable, until it sees gnt_o[i]; gnt_o is a one-cycle acceptance pulse.
  input  logic [NREQ-1:0]       req_i,
  input  logic [2*NREQ-1:0]     req_op_i,
  input  logic [WIDTH*NREQ-1:0] req_arg_i,
  output logic [NREQ-1:0]       gnt_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [IDW-1:0]        done_id_o,
  output logic [WIDTH-1:0]      done_val_o,
  output logic                  ctr_ld_o,
  output logic [WIDTH-1:0]      ctr_ld_val_o,
  output logic                  ctr_dir_o,
  output logic                  ctr_en_o,
  input  logic [WIDTH-1:0]      ctr_out_i,
`ifdef CTR_ARB_SAT_EN
  output logic                  sat_o,
`endif
  output logic [1:0]            dbg_state_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_e;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_UP   = 2'b01;
  localparam logic [1:0] OP_DOWN = 2'b10;

  state_e           state_q, state_d;
  logic [IDW-1:0]   id_q;
  logic [IDW-1:0]   last_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] rem_q;
  logic             first_q;
  logic [WIDTH-1:0] ld_val_q;
  logic             dir_q;
  logic [IDW-1:0]   done_id_q;
  logic [WIDTH-1:0] done_val_q;

  logic             win_vld, hi_vld;
  logic [IDW-1:0]   win_id, hi_id, lo_id;
  logic [1:0]       win_op;
  logic [WIDTH-1:0] win_arg;
  logic             is_step;
  logic             sat_hit;
  logic             step_en;

  // Lowest requester above last_q wins; otherwise the lowest overall (wrap-around).
  always_comb begin
    hi_vld  = 1'b0;
    hi_id   = '0;
    win_vld = 1'b0;
    lo_id   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (((req_i >> i) & NREQ'(1)) != '0) begin
        if (!hi_vld && (i > int'(last_q))) begin
          hi_vld = 1'b1;
          hi_id  = IDW'(i);
        end
        if (!win_vld) begin
          win_vld = 1'b1;
          lo_id   = IDW'(i);
        end
      end
    end
    win_id  = hi_vld ? hi_id : lo_id;
    win_op  = 2'(req_op_i >> (2 * win_id));
    win_arg = WIDTH'(req_arg_i >> (WIDTH * win_id));
  end

  assign is_step = (op_q == OP_UP) || (op_q == OP_DOWN);

`ifdef CTR_ARB_SAT_EN
  logic sat_q;
  assign sat_hit = (state_q == EXEC) && is_step && (rem_q != '0) &&
                   (((op_q == OP_UP) && (ctr_out_i == '1)) ||
                    ((op_q == OP_DOWN) && (ctr_out_i == '0)));
  assign sat_o = sat_q;
`else
  assign sat_hit = 1'b0;
`endif

  assign step_en = (state_q == EXEC) && is_step && (rem_q != '0) && !sat_hit;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (win_vld) state_d = EXEC;
      EXEC: begin
        if (!is_step || (rem_q == '0) || sat_hit || (rem_q == WIDTH'(1)))
          state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    gnt_o        = '0;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    ctr_ld_o     = 1'b0;
    ctr_en_o     = 1'b0;
    done_id_o    = done_id_q;
    done_val_o   = done_val_q;
    ctr_ld_val_o = ld_val_q;
    ctr_dir_o    = dir_q;
    dbg_state_o  = state_q;
    case (state_q)
      EXEC: begin
        busy_o   = 1'b1;
        gnt_o    = first_q ? (NREQ'(1) << id_q) : '0;
        ctr_ld_o = (op_q == OP_LOAD);
        ctr_en_o = step_en;
      end
      DONE: begin
        busy_o     = 1'b1;
        done_o     = 1'b1;
        done_id_o  = id_q;
        done_val_o = ctr_out_i;
      end
      default: ;
    endcase
  end

  // Command datapath; ld_val/dir only change when a command that drives them is accepted.
  always_ff @(posedge clk) begin
    if (!rst) begin
      id_q       <= '0;
      last_q     <= IDW'(NREQ - 1);
      op_q       <= '0;
      rem_q      <= '0;
      first_q    <= 1'b0;
      ld_val_q   <= '0;
      dir_q      <= 1'b0;
      done_id_q  <= '0;
      done_val_q <= '0;
`ifdef CTR_ARB_SAT_EN
      sat_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (win_vld) begin
            id_q    <= win_id;
            op_q    <= win_op;
            rem_q   <= win_arg;
            first_q <= 1'b1;
            if (win_op == OP_LOAD) ld_val_q <= win_arg;
            if ((win_op == OP_UP) || (win_op == OP_DOWN)) dir_q <= (win_op == OP_UP);
`ifdef CTR_ARB_SAT_EN
            sat_q   <= 1'b0;
`endif
          end
        end
        EXEC: begin
          first_q <= 1'b0;
          if (step_en) rem_q <= rem_q - WIDTH'(1);
          if (sat_hit) begin
            rem_q <= '0;
`ifdef CTR_ARB_SAT_EN
            sat_q <= 1'b1;
`endif
          end
        end
        DONE: begin
          last_q     <= id_q;
          done_id_q  <= id_q;
          done_val_q <= ctr_out_i;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_cmd_arbiter.sv
// Directed bench for counter_cmd_arbiter with an attached up/down counter and a done scoreboard.
module tb_counter_cmd_arbiter;
  localparam int NR = 4;
  localparam int W  = 4;
  localparam int IW = 2;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_UP   = 2'b01;
  localparam logic [1:0] OP_DOWN = 2'b10;
  localparam logic [1:0] OP_READ = 2'b11;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [NR-1:0]   req = '0;
  logic [2*NR-1:0] req_op = '0;
  logic [W*NR-1:0] req_arg = '0;
  logic [NR-1:0]   gnt;
  logic            busy, done;
  logic [IW-1:0]   done_id;
  logic [W-1:0]    done_val;
  logic            ctr_ld, ctr_dir, ctr_en;
  logic [W-1:0]    ctr_ld_val;
  logic [W-1:0]    cnt = '0;
  logic [1:0]      dbg_state;
`ifdef CTR_ARB_SAT_EN
  logic            sat;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [W+IW-1:0] exp_q[$];

  counter_cmd_arbiter #(.NREQ(NR), .WIDTH(W), .IDW(IW)) dut (
    .clk(clk), .rst(rst),
    .req_i(req), .req_op_i(req_op), .req_arg_i(req_arg),
    .gnt_o(gnt), .busy_o(busy), .done_o(done),
    .done_id_o(done_id), .done_val_o(done_val),
    .ctr_ld_o(ctr_ld), .ctr_ld_val_o(ctr_ld_val),
    .ctr_dir_o(ctr_dir), .ctr_en_o(ctr_en),
    .ctr_out_i(cnt),
`ifdef CTR_ARB_SAT_EN
    .sat_o(sat),
`endif
    .dbg_state_o(dbg_state)
  );

  // Clock and the shared counter (own state, never reset by the arbiter)
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ctr_ld)      cnt <= ctr_ld_val;
    else if (ctr_en) cnt <= ctr_dir ? cnt + 1'b1 : cnt - 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_check();
    logic [W+IW-1:0] e;
    if (exp_q.size() == 0) begin
      chk("sb_entry_present", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk("done_id", 32'(done_id), 32'(e[W+IW-1:W]));
      chk("done_val", 32'(done_val), 32'(e[W-1:0]));
    end
  endtask

  task automatic issue(input int id, input logic [1:0] op, input logic [W-1:0] arg);
    req[id] = 1'b1;
    req_op[2*id +: 2] = op;
    req_arg[W*id +: W] = arg;
  endtask

  task automatic wait_gnt(output int lat, output bit got);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (gnt !== '0) got = 1'b1;
    end
  endtask

  // Follows a granted command from its gnt cycle (lat0) to done, then checks the idle gap.
  task automatic track(input logic [1:0] op, input logic [W-1:0] arg, input int exp_en,
                       input int exp_ld, input int exp_lat, input logic exp_sat, input int lat0);
    int lat, n_en, n_ld, n_gnt, n_bad;
    bit seen;
    lat = lat0; n_en = 0; n_ld = 0; n_gnt = 0; n_bad = 0; seen = 1'b0;
    while (!seen && lat < 60) begin
      if (lat != lat0 && gnt !== '0) n_gnt++;
      if (ctr_en === 1'b1) begin
        n_en++;
        if (ctr_dir !== (op == OP_UP)) n_bad++;
      end
      if (ctr_ld === 1'b1) begin
        n_ld++;
        if (ctr_ld_val !== arg) n_bad++;
      end
      if (done === 1'b1) seen = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("done_latency", lat, exp_lat);
    chk("en_cycles", n_en, exp_en);
    chk("ld_cycles", n_ld, exp_ld);
    chk("gnt_single_pulse", n_gnt, 0);
    chk("ctr_dir_ldval", n_bad, 0);
    chk("busy_at_done", 32'(busy), 32'd1);
    sb_check();
`ifdef CTR_ARB_SAT_EN
    chk("sat", 32'(sat), 32'(exp_sat));
`else
    if (exp_sat) chk("sat_unexpected_in_wrap_build", 32'd1, 32'd0);
`endif
    @(negedge clk);
    chk("done_pulse_width", 32'(done), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("gnt_idle", 32'(gnt), 32'd0);
  endtask

  task automatic run_cmd(input int id, input logic [1:0] op, input logic [W-1:0] arg,
                         input logic [W-1:0] exp_val, input int exp_en, input int exp_ld,
                         input int exp_lat, input logic exp_sat);
    int lat;
    bit got;
    exp_q.push_back({IW'(id), exp_val});
    @(negedge clk);
    issue(id, op, arg);
    wait_gnt(lat, got);
    chk("gnt_seen", 32'(got), 32'd1);
    chk("gnt_latency", lat, 1);
    chk("gnt_onehot", 32'(gnt), 32'(1 << id));
    req[id] = 1'b0;
    track(op, arg, exp_en, exp_ld, exp_lat, exp_sat, lat);
  endtask

  initial begin
    int lat;
    bit got;
    // Reset
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ctr_ld", 32'(ctr_ld), 32'd0);
    chk("rst_ctr_en", 32'(ctr_en), 32'd0);
    chk("rst_ctr_dir", 32'(ctr_dir), 32'd0);
    chk("rst_ctr_ld_val", 32'(ctr_ld_val), 32'd0);
    chk("rst_done_id", 32'(done_id), 32'd0);
    chk("rst_done_val", 32'(done_val), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b1;

    run_cmd(0, OP_LOAD, 4'h9, 4'h9, 0, 1, 2, 1'b0);
    run_cmd(1, OP_UP,   4'd3, 4'hC, 3, 0, 4, 1'b0);
    run_cmd(3, OP_LOAD, 4'h2, 4'h2, 0, 1, 2, 1'b0);
`ifdef CTR_ARB_SAT_EN
    run_cmd(2, OP_DOWN, 4'd5, 4'h0, 2, 0, 4, 1'b1);
`else
    run_cmd(2, OP_DOWN, 4'd5, 4'hD, 5, 0, 6, 1'b0);
`endif

    // Round robin: last served 2, requesters 0 and 3 raised together
`ifdef CTR_ARB_SAT_EN
    exp_q.push_back({2'd3, 4'h0});
    exp_q.push_back({2'd0, 4'h0});
`else
    exp_q.push_back({2'd3, 4'hD});
    exp_q.push_back({2'd0, 4'hD});
`endif
    @(negedge clk);
    issue(0, OP_READ, 4'h0);
    issue(3, OP_READ, 4'h0);
    wait_gnt(lat, got);
    chk("rr_first_gnt", 32'(gnt), 32'b1000);
    req[3] = 1'b0;
    track(OP_READ, 4'h0, 0, 0, 2, 1'b0, lat);
    @(negedge clk);
    chk("rr_second_gnt", 32'(gnt), 32'b0001);
    req[0] = 1'b0;
    track(OP_READ, 4'h0, 0, 0, 2, 1'b0, 1);

    run_cmd(1, OP_LOAD, 4'h7, 4'h7, 0, 1, 2, 1'b0);
    run_cmd(2, OP_READ, 4'h0, 4'h7, 0, 0, 2, 1'b0);
    run_cmd(3, OP_UP,   4'd0, 4'h7, 0, 0, 2, 1'b0);

    // Reset during EXEC of up 10; req[1] stays asserted across the reset
    @(negedge clk);
    issue(1, OP_UP, 4'd10);
    wait_gnt(lat, got);
    chk("mid_rst_gnt", 32'(gnt), 32'b0010);
    repeat (2) @(negedge clk);
    chk("mid_rst_en_before", 32'(ctr_en), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_ctr_en", 32'(ctr_en), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("regrant_gnt", 32'(gnt), 32'b0010);
    req[1] = 1'b0;
`ifdef CTR_ARB_SAT_EN
    exp_q.push_back({2'd1, 4'hF});
    track(OP_UP, 4'd10, 5, 0, 7, 1'b1, 1);
`else
    exp_q.push_back({2'd1, 4'h4});
    track(OP_UP, 4'd10, 10, 0, 11, 1'b0, 1);
`endif

    chk("sb_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
